decay_scheduler: RTL and testbench

- Sequences the leaky-integrate-and-fire potential-decay step across all neurons in a cluster, once per timestep.
- On each timestep pulse, walks every neuron address. For each neuron it reads the membrane potential (IEEE-754 single) from the potential RAM, applies that neuron's configured decay rate, and writes the result back.
- Power-of-two decays are exponent adjustments done in-block. The ×0.75 mode borrows the shared FP adder through a req/ack handshake.
- Sits between the timestep controller, the per-cluster potential RAM and the shared Addition_Subtraction unit.

---
 rtl/decay_pkg.sv | 40 ++++
 rtl/decay_scheduler_if.sv | 45 ++++
 rtl/decay_exp_shift.sv | 34 +++
 rtl/decay_scheduler.sv | 165 ++++++++++++++++
 tb/tb_decay_scheduler.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decay_pkg.sv
// Shared constants, FSM encoding and rate decode for the LIF decay scheduler.
// Rate codes select an exponent shift or the x/2 + x/4 adder path.
package decay_pkg;

    localparam logic [3:0] RATE_DIV1         = 4'b0001;
    localparam logic [3:0] RATE_DIV2         = 4'b0010;
    localparam logic [3:0] RATE_DIV4         = 4'b0100;
    localparam logic [3:0] RATE_DIV8         = 4'b1000;
    localparam logic [3:0] RATE_HALF_QUARTER = 4'b0011;

    localparam int SIGN_BIT = 31;
    localparam int EXP_MSB  = 30;
    localparam int EXP_LSB  = 23;

    localparam logic [7:0] EXP_INF = 8'hFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WAIT,
        S_DECAY,
        S_ADD,
        S_WR,
        S_DONE
    } state_e;

    // Unknown codes fall back to /1 (no shift).
    function automatic logic [1:0] rate_to_k(input logic [3:0] rate);
        logic [1:0] k;
        k = 2'd0;
        unique case (1'b1)
            (rate == RATE_DIV2): k = 2'd1;
            (rate == RATE_DIV4): k = 2'd2;
            (rate == RATE_DIV8): k = 2'd3;
            default:             k = 2'd0;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/decay_scheduler_if.sv
// Potential-RAM and shared FP adder bundle driven by the decay scheduler.
// The scheduler is the master of both the RAM port and the adder request.
interface decay_scheduler_if #(
    parameter int ADDR_W = 5
);

    logic              mem_rd_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_rd_data;
    logic              mem_wr_en;
    logic [31:0]       mem_wr_data;

    logic              add_req;
    logic [31:0]       add_a;
    logic [31:0]       add_b;
    logic              add_ack;
    logic [31:0]       add_result;

    modport master (
        output mem_rd_en,
        output mem_addr,
        input  mem_rd_data,
        output mem_wr_en,
        output mem_wr_data,
        output add_req,
        output add_a,
        output add_b,
        input  add_ack,
        input  add_result
    );

    modport slave (
        input  mem_rd_en,
        input  mem_addr,
        output mem_rd_data,
        input  mem_wr_en,
        input  mem_wr_data,
        input  add_req,
        input  add_a,
        input  add_b,
        output add_ack,
        output add_result
    );

endinterface

// File: rtl/decay_exp_shift.sv
// Divides an IEEE-754 single by 2**k via the exponent field.
// Inf/NaN pass through; results that would go subnormal flush to signed zero.
module decay_exp_shift
    import decay_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  k_i,
    output logic [31:0] word_o
);

    logic       sign;
    logic [7:0] exp;
    logic [7:0] k_ext;

    assign sign  = word_i[SIGN_BIT];
    assign exp   = word_i[EXP_MSB:EXP_LSB];
    assign k_ext = {6'd0, k_i};

    always_comb begin
        word_o = word_i;
        unique case (1'b1)
            (exp == EXP_INF): begin
                word_o = word_i;
            end
            ((k_i != 2'd0) && (exp <= k_ext)): begin
                word_o = {sign, 31'd0};
            end
            default: begin
                word_o = {sign, exp - k_ext, word_i[EXP_LSB-1:0]};
            end
        endcase
    end

endmodule

// File: rtl/decay_scheduler.sv
// Walks every neuron once per timestep: read potential, decay, write back.
// Shift rates are handled locally; the x0.75 rate borrows the shared adder.
module decay_scheduler
    import decay_pkg::*;
#(
    parameter int NUM_NEURONS = 20,
    parameter int ADDR_W      = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              timestep_start,
    input  logic              cfg_we,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [3:0]        cfg_rate,
    decay_scheduler_if.master bus,
    output logic              busy,
    output logic              done,
    output logic              overrun
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NUM_NEURONS - 1);

    state_e            state_q;
    logic [ADDR_W-1:0] cnt_q;
    logic [3:0]        rate_q [NUM_NEURONS];
    logic [3:0]        rate_hold_q;
    logic [31:0]       word_q;

    logic              rd_en_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       wr_data_q;
    logic              req_q;
    logic [31:0]       a_q;
    logic [31:0]       b_q;
    logic              busy_q;
    logic              done_q;
    logic              overrun_q;

    logic [1:0]        k_main;
    logic [31:0]       sh_main;
    logic [31:0]       sh_quarter;

    assign k_main = (rate_hold_q == RATE_HALF_QUARTER)
                  ? 2'd1
                  : rate_to_k(rate_hold_q);

    decay_exp_shift u_shift_main (
        .word_i (word_q),
        .k_i    (k_main),
        .word_o (sh_main)
    );

    decay_exp_shift u_shift_quarter (
        .word_i (word_q),
        .k_i    (2'd2),
        .word_o (sh_quarter)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_NEURONS; i++) begin
                rate_q[i] <= RATE_DIV2;
            end
        end else if (cfg_we && (cfg_addr <= LAST)) begin
            rate_q[cfg_addr] <= cfg_rate;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rate_hold_q <= RATE_DIV2;
            word_q      <= '0;
            rd_en_q     <= 1'b0;
            wr_en_q     <= 1'b0;
            addr_q      <= '0;
            wr_data_q   <= '0;
            req_q       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            // Strobes are single-cycle; the address parks at 0 between them.
            rd_en_q   <= 1'b0;
            wr_en_q   <= 1'b0;
            addr_q    <= '0;
            done_q    <= 1'b0;
            overrun_q <= timestep_start && (state_q != S_IDLE);
            unique case (state_q)
                S_IDLE: begin
                    if (timestep_start) begin
                        state_q <= S_RD;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        rd_en_q <= 1'b1;
                    end
                end
                S_RD: begin
                    rate_hold_q <= rate_q[cnt_q];
                    state_q     <= S_WAIT;
                end
                S_WAIT: begin
                    word_q  <= bus.mem_rd_data;
                    state_q <= S_DECAY;
                end
                S_DECAY: begin
                    if (rate_hold_q == RATE_HALF_QUARTER) begin
                        req_q   <= 1'b1;
                        a_q     <= sh_main;
                        b_q     <= sh_quarter;
                        state_q <= S_ADD;
                    end else begin
                        wr_en_q   <= 1'b1;
                        addr_q    <= cnt_q;
                        wr_data_q <= sh_main;
                        state_q   <= S_WR;
                    end
                end
                S_ADD: begin
                    if (bus.add_ack) begin
                        req_q     <= 1'b0;
                        wr_en_q   <= 1'b1;
                        addr_q    <= cnt_q;
                        wr_data_q <= bus.add_result;
                        state_q   <= S_WR;
                    end
                end
                S_WR: begin
                    if (cnt_q == LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q   <= cnt_q + ADDR_W'(1);
                        rd_en_q <= 1'b1;
                        addr_q  <= cnt_q + ADDR_W'(1);
                        state_q <= S_RD;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_rd_en   = rd_en_q;
    assign bus.mem_wr_en   = wr_en_q;
    assign bus.mem_addr    = addr_q;
    assign bus.mem_wr_data = wr_data_q;
    assign bus.add_req     = req_q;
    assign bus.add_a       = a_q;
    assign bus.add_b       = b_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign overrun         = overrun_q;

endmodule

// File: tb/tb_decay_scheduler.sv
// Directed sweeps against a RAM model, an adder model and a write scoreboard.
// Covers shift rates, the adder path, overrun, mid-sweep config and reset.
module tb_decay_scheduler;
    import decay_pkg::*;

    localparam int N  = 20;
    localparam int AW = 5;
    localparam logic [31:0] ADD_RES = 32'h41A70A3D;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          timestep_start = 1'b0;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [3:0]    cfg_rate = '0;
    logic          busy;
    logic          done;
    logic          overrun;

    decay_scheduler_if #(.ADDR_W(AW)) bus();

    decay_scheduler #(.NUM_NEURONS(N), .ADDR_W(AW)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .timestep_start (timestep_start),
        .cfg_we         (cfg_we),
        .cfg_addr       (cfg_addr),
        .cfg_rate       (cfg_rate),
        .bus            (bus),
        .busy           (busy),
        .done           (done),
        .overrun        (overrun)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    wr_t         sb[$];
    logic [63:0] opq[$];
    logic [31:0] ram[N];
    logic [31:0] ref_mem[N];
    logic [3:0]  rate_m[N];
    logic [31:0] last_a = '0;
    logic [31:0] last_b = '0;
    int n_chk = 0;
    int n_fail = 0;
    int n_done = 0;
    int n_ovr = 0;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] m_shift(input logic [31:0] x, input int k);
        logic [7:0] e;
        e = x[30:23];
        if (e == 8'hFF) return x;
        if (k > 0 && int'(e) <= k) return {x[31], 31'b0};
        return {x[31], e - 8'(k), x[22:0]};
    endfunction

    function automatic int m_k(input logic [3:0] r);
        case (r)
            4'b0010: return 1;
            4'b0100: return 2;
            4'b1000: return 3;
            default: return 0;
        endcase
    endfunction

    function automatic logic [31:0] ctl_vec();
        return {24'b0, bus.mem_rd_en, bus.mem_wr_en, bus.add_req, busy, done,
                overrun, |bus.mem_addr, |{bus.mem_wr_data, bus.add_a, bus.add_b}};
    endfunction

    initial begin : ram_model
        bit            rp;
        logic [AW-1:0] ra;
        wr_t           e;
        bus.mem_rd_data = 32'hDEADBEEF;
        forever begin
            @(negedge clk);
            rp = bus.mem_rd_en;
            ra = bus.mem_addr;
            if (done) n_done++;
            if (overrun) n_ovr++;
            if (rst_n && !bus.mem_rd_en && !bus.mem_wr_en)
                check("addr_idle", 32'(bus.mem_addr), 0);
            if (bus.mem_wr_en) begin
                check("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    check("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
                    check("wr_data", bus.mem_wr_data, e.data);
                end
                ram[bus.mem_addr] = bus.mem_wr_data;
            end
            @(posedge clk);
            #1;
            bus.mem_rd_data = rp ? ram[ra] : 32'hDEADBEEF;
        end
    end

    initial begin : add_model
        logic [63:0] op;
        bus.add_ack = 1'b0;
        bus.add_result = '0;
        forever begin
            @(negedge clk);
            if (bus.add_req) begin
                op = (opq.size() != 0) ? opq.pop_front() : 64'h0;
                last_a = bus.add_a;
                last_b = bus.add_b;
                check("add_a", bus.add_a, op[63:32]);
                check("add_b", bus.add_b, op[31:0]);
                @(negedge clk);
                check("add_req_hold1", 32'(bus.add_req), 1);
                check("add_a_stable", bus.add_a, op[63:32]);
                @(posedge clk);
                #1;
                bus.add_ack = 1'b1;
                bus.add_result = ADD_RES;
                @(negedge clk);
                check("add_req_hold2", 32'(bus.add_req), 1);
                check("add_b_stable", bus.add_b, op[31:0]);
                @(posedge clk);
                #1;
                bus.add_ack = 1'b0;
                bus.add_result = '0;
                @(negedge clk);
                check("add_req_drop", 32'(bus.add_req), 0);
            end
        end
    end

    task automatic cfg(input int a, input logic [3:0] r);
        @(posedge clk);
        #1;
        cfg_we = 1'b1;
        cfg_addr = AW'(a);
        cfg_rate = r;
        rate_m[a] = r;
        @(posedge clk);
        #1;
        cfg_we = 1'b0;
    endtask

    task automatic start_sweep(output int n_add);
        n_add = 0;
        for (int i = 0; i < N; i++) begin
            logic [31:0] r;
            if (rate_m[i] == 4'b0011) begin
                opq.push_back({m_shift(ref_mem[i], 1), m_shift(ref_mem[i], 2)});
                r = ADD_RES;
                n_add++;
            end else begin
                r = m_shift(ref_mem[i], m_k(rate_m[i]));
            end
            sb.push_back('{addr: AW'(i), data: r});
            ref_mem[i] = r;
        end
        @(posedge clk);
        #1;
        timestep_start = 1'b1;
        @(posedge clk);
        #1;
        timestep_start = 1'b0;
    endtask

    // mode: 0 plain, 1 overrun pulses, 2 mid-sweep config, 3 reset at neuron 7
    task automatic run(input int n_add, input int mode, input string tag);
        int cyc = 0;
        int d0 = n_done;
        int o0 = n_ovr;
        bit hit = 0;
        bit rst_hit = 0;
        while (cyc < 600 && !hit && !rst_hit) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check({tag, "_busy"}, 32'(busy), 1);
            if (mode == 1) timestep_start = (cyc == 30);
            if (mode == 2) begin
                cfg_we = bus.mem_rd_en && (bus.mem_addr == 5 || bus.mem_addr == 10);
                cfg_addr = (bus.mem_addr == 5) ? AW'(19) : AW'(10);
                cfg_rate = (bus.mem_addr == 5) ? 4'b0001 : 4'b1000;
            end
            if (mode == 3 && bus.mem_rd_en && bus.mem_addr == 7) begin
                rst_n = 1'b0;
                #1;
                check("rst_ctl", ctl_vec(), 0);
                sb.delete();
                opq.delete();
                for (int i = 0; i < N; i++) begin
                    ref_mem[i] = ram[i];
                    rate_m[i] = 4'b0010;
                end
                repeat (2) @(negedge clk);
                check("rst_hold_ctl", ctl_vec(), 0);
                rst_n = 1'b1;
                rst_hit = 1;
            end
            if (done) hit = 1;
        end
        cfg_we = 1'b0;
        if (mode == 3) begin
            check({tag, "_rst_reached"}, 32'(rst_hit), 1);
        end else begin
            check({tag, "_done_seen"}, 32'(hit), 1);
            check({tag, "_latency"}, 32'(cyc), 32'(4 * N + 1 + 3 * n_add));
            check({tag, "_busy_at_done"}, 32'(busy), 0);
            if (mode == 1) timestep_start = 1'b1;
            @(posedge clk);
            #1;
            timestep_start = 1'b0;
            repeat (4) @(negedge clk);
            check({tag, "_idle"}, 32'(busy), 0);
            check({tag, "_done_cnt"}, 32'(n_done - d0), 1);
            check({tag, "_ovr_cnt"}, 32'(n_ovr - o0), (mode == 1) ? 2 : 0);
            check({tag, "_sb_drained"}, 32'(sb.size()), 0);
        end
    endtask

    initial begin : stim
        int na;
        logic [31:0] v19;
        for (int i = 0; i < N; i++) begin
            ram[i] = $urandom;
            rate_m[i] = 4'b0010;
        end
        ram[0] = 32'h41DEB852;
        ram[1] = 32'hC1DEB852;
        ram[2] = 32'h41DEB852;
        ram[3] = 32'h00800000;
        ram[4] = 32'h7FC00000;
        ram[5] = 32'h00000000;
        for (int i = 0; i < N; i++) ref_mem[i] = ram[i];

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_ctl", ctl_vec(), 0);
        rst_n = 1'b1;

        cfg(1, 4'b0100);
        cfg(2, 4'b1000);
        cfg(3, 4'b0100);
        cfg(4, 4'b1000);
        cfg(7, 4'b0101);
        cfg(8, 4'b0001);
        start_sweep(na);
        run(na, 0, "sweep1");
        check("n0_div2", ram[0], 32'h415EB852);
        check("n1_div4_neg", ram[1], 32'hC0DEB852);
        check("n2_div8", ram[2], 32'h405EB852);
        check("n3_flush", ram[3], 32'h00000000);
        check("n4_nan", ram[4], 32'h7FC00000);
        check("n5_zero", ram[5], 32'h00000000);

        ram[6] = 32'h41DEB852;
        ref_mem[6] = ram[6];
        cfg(6, 4'b0011);
        start_sweep(na);
        run(na, 0, "sweep2_add");
        check("add_a_const", last_a, 32'h415EB852);
        check("add_b_const", last_b, 32'h40DEB852);
        check("n6_add", ram[6], ADD_RES);

        start_sweep(na);
        run(na, 1, "sweep3_ovr");

        v19 = ref_mem[19];
        rate_m[19] = 4'b0001;
        start_sweep(na);
        rate_m[10] = 4'b1000;
        run(na, 2, "sweep4_cfg");
        check("n19_pass", ram[19], v19);

        start_sweep(na);
        run(na, 0, "sweep5");

        start_sweep(na);
        run(na, 3, "sweep6_rst");

        start_sweep(na);
        run(na, 0, "sweep7_post_rst");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
